// File: rtl/dd_debounce.sv
// dd_debounce: per-bit debouncer and edge detector for slow external levels.
//
// The input is expected to come straight from a double-flop synchronizer.
// Each bit has its own small FSM and stability counter. A new level is
// accepted only after it differs from the current debounced level on
// DEBOUNCE_CYCLES consecutive clk edges. On an accept, the debounced level
// and a one-cycle rise or fall pulse appear together.
//
// Optional feature macro: DD_DEBOUNCE_STICKY_EN
//   defined   : chg_sticky_o[k] sets one cycle after an accept on bit k and
//               holds until chg_clr_i[k] is high at a clk edge. If a set and
//               a clear land on the same edge, the set wins.
//   undefined : chg_sticky_o is tied low and chg_clr_i is ignored. Both
//               ports remain so instantiations do not change.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   data_sync_i   [WIDTH] synchronized raw level
//   data_db_o     [WIDTH] debounced level (registered)
//   rise_pulse_o  [WIDTH] one-cycle pulse on an accepted 0->1 transition
//   fall_pulse_o  [WIDTH] one-cycle pulse on an accepted 1->0 transition
//   chg_clr_i     [WIDTH] sticky change flag clear
//   chg_sticky_o  [WIDTH] sticky change flag
//
// Per-bit FSM:
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_STABLE  | input matches the debounced level, counter idle at 0
//   ST_PENDING | input differs; cnt holds the differing edges still needed

module dd_debounce #(
  parameter int unsigned      WIDTH           = 1,
  parameter int unsigned      CNT_W           = 16,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RST_VAL         = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_sync_i,
  output logic [WIDTH-1:0] data_db_o,
  output logic [WIDTH-1:0] rise_pulse_o,
  output logic [WIDTH-1:0] fall_pulse_o,
  input  logic [WIDTH-1:0] chg_clr_i,
  output logic [WIDTH-1:0] chg_sticky_o
);

  if ((DEBOUNCE_CYCLES < 1) ||
      (64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_param
    $error("dd_debounce: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
  end

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  // The counter runs down: entering PENDING loads the number of further
  // differing edges required, and the edge that finds it at 1 accepts.
  // It therefore never goes below 1 while pending and cannot wrap.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(1);
  localparam bit               INSTANT  = (DEBOUNCE_CYCLES == 1);

  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] differ;

  assign differ = data_sync_i ^ db_q;

  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        ST_STABLE: begin
          cnt_d[k] = '0;
          if (differ[k]) begin
            if (INSTANT) begin
              db_d[k]   = data_sync_i[k];
              rise_d[k] = data_sync_i[k];
              fall_d[k] = ~data_sync_i[k];
            end else begin
              state_d[k] = ST_PENDING;
              cnt_d[k]   = LOAD_VAL;
            end
          end
        end
        ST_PENDING: begin
          if (!differ[k]) begin
            // glitch: back to the current level before the count finished
            state_d[k] = ST_STABLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == TERM_VAL) begin
            state_d[k] = ST_STABLE;
            cnt_d[k]   = '0;
            db_d[k]    = data_sync_i[k];
            rise_d[k]  = data_sync_i[k];
            fall_d[k]  = ~data_sync_i[k];
          end else begin
            cnt_d[k] = cnt_q[k] - TERM_VAL;
          end
        end
        default: begin
          state_d[k] = ST_STABLE;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(WIDTH); k++) begin
        state_q[k] <= ST_STABLE;
        cnt_q[k]   <= '0;
      end
      db_q   <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int k = 0; k < int'(WIDTH); k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign data_db_o    = db_q;
  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;

`ifdef DD_DEBOUNCE_STICKY_EN
  logic [WIDTH-1:0] sticky_q, sticky_d;

  // Set comes from the registered pulses, so the flag lands one cycle after
  // the pulse; OR-ing it in after the clear makes set win over clear.
  always_comb begin
    sticky_d = (sticky_q & ~chg_clr_i) | rise_q | fall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign chg_sticky_o = sticky_q;
`else
  logic unused_chg_clr;
  assign unused_chg_clr = ^chg_clr_i;
  assign chg_sticky_o   = '0;
`endif

endmodule

// File: tb/tb_dd_debounce.sv
// Bench for dd_debounce: two instances (DEBOUNCE_CYCLES=4 and =1, WIDTH=2)
// share the same stimulus. A reference model keeps a short window of past
// samples per bit and accepts a new level when the last N samples since the
// previous accept/reset all differ from the current debounced level.

module tb_dd_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] data_sync;
  logic [1:0] chg_clr;

  logic [1:0] db4, rise4, fall4, stk4;
  logic [1:0] db1, rise1, fall1, stk1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dd_debounce #(
    .WIDTH(2), .CNT_W(16), .DEBOUNCE_CYCLES(4), .RST_VAL(2'b00)
  ) u_dut4 (
    .clk(clk), .rst(rst), .data_sync_i(data_sync),
    .data_db_o(db4), .rise_pulse_o(rise4), .fall_pulse_o(fall4),
    .chg_clr_i(chg_clr), .chg_sticky_o(stk4)
  );

  dd_debounce #(
    .WIDTH(2), .CNT_W(16), .DEBOUNCE_CYCLES(1), .RST_VAL(2'b00)
  ) u_dut1 (
    .clk(clk), .rst(rst), .data_sync_i(data_sync),
    .data_db_o(db1), .rise_pulse_o(rise1), .fall_pulse_o(fall1),
    .chg_clr_i(chg_clr), .chg_sticky_o(stk1)
  );

  // reference model, index 0 -> N=4 instance, index 1 -> N=1 instance
  int         dn [2] = '{4, 1};
  logic [7:0] mh     [2][2];
  int         msince [2][2];
  logic [1:0] mdb    [2];
  logic [1:0] mrise  [2];
  logic [1:0] mfall  [2];
  logic [1:0] mstk   [2];

  task automatic model_edge(input logic r, input logic [1:0] d, input logic [1:0] clr);
    for (int u = 0; u < 2; u++) begin
      if (r) begin
        mdb[u]   = 2'b00;
        mrise[u] = 2'b00;
        mfall[u] = 2'b00;
        mstk[u]  = 2'b00;
        for (int k = 0; k < 2; k++) begin
          mh[u][k]     = 8'h00;
          msince[u][k] = 0;
        end
      end else begin
        logic [1:0] nr;
        logic [1:0] nf;
`ifdef DD_DEBOUNCE_STICKY_EN
        mstk[u] = (mstk[u] & ~clr) | mrise[u] | mfall[u];
`else
        mstk[u] = 2'b00;
`endif
        nr = 2'b00;
        nf = 2'b00;
        for (int k = 0; k < 2; k++) begin
          bit ok;
          mh[u][k] = {mh[u][k][6:0], d[k]};
          if (msince[u][k] < 1000) msince[u][k]++;
          ok = (msince[u][k] >= dn[u]);
          for (int i = 0; i < dn[u]; i++)
            if (mh[u][k][i] == mdb[u][k]) ok = 1'b0;
          if (ok) begin
            mdb[u][k]    = d[k];
            nr[k]        = d[k];
            nf[k]        = ~d[k];
            msince[u][k] = 0;
          end
        end
        mrise[u] = nr;
        mfall[u] = nf;
      end
    end
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] d, input logic [1:0] clr);
    @(negedge clk);
    rst       = r;
    data_sync = d;
    chg_clr   = clr;
    @(posedge clk);
    model_edge(r, d, clr);
    #1;
    check("db_n4",     db4,   mdb[0]);
    check("rise_n4",   rise4, mrise[0]);
    check("fall_n4",   fall4, mfall[0]);
    check("sticky_n4", stk4,  mstk[0]);
    check("db_n1",     db1,   mdb[1]);
    check("rise_n1",   rise1, mrise[1]);
    check("fall_n1",   fall1, mfall[1]);
    check("sticky_n1", stk1,  mstk[1]);
  endtask

  initial begin
    logic [1:0] rd;
    rst       = 1'b1;
    data_sync = 2'b00;
    chg_clr   = 2'b00;

    // reset held with input high, then released: accept after 4th edge
    repeat (3) step(1'b1, 2'b11, 2'b00);
    check("reset_db_const", db4, 2'b00);
    repeat (6) step(1'b0, 2'b11, 2'b00);

    // glitch reject on bit0, then a full 4-cycle high
    step(1'b1, 2'b00, 2'b00);
    repeat (3) step(1'b0, 2'b01, 2'b00);
    check("glitch_no_accept", db4, 2'b00);
    repeat (2) step(1'b0, 2'b00, 2'b00);
    repeat (5) step(1'b0, 2'b01, 2'b00);
    check("glitch_then_accept", db4, 2'b01);

    // fall on bit0 held for 10 cycles
    repeat (10) step(1'b0, 2'b00, 2'b00);
    check("fall_settled", db4, 2'b00);

    // reset mid-count on bit1
    repeat (2) step(1'b0, 2'b10, 2'b00);
    step(1'b1, 2'b10, 2'b00);
    repeat (3) step(1'b0, 2'b10, 2'b00);
    check("midcount_not_yet", db4, 2'b00);
    step(1'b0, 2'b10, 2'b00);
    check("midcount_accept", rise4, 2'b10);
    repeat (2) step(1'b0, 2'b10, 2'b00);

    // bit0 toggling every cycle: N=1 instance follows, N=4 never accepts
    for (int i = 0; i < 8; i++) step(1'b0, {1'b1, 1'(i % 2 == 0)}, 2'b00);

    // sticky: rise on bit1, hold, clear, then set and clear on the same edge
    step(1'b1, 2'b00, 2'b00);
    repeat (4) step(1'b0, 2'b10, 2'b00);
    repeat (3) step(1'b0, 2'b10, 2'b00);
    step(1'b0, 2'b10, 2'b10);
    repeat (2) step(1'b0, 2'b10, 2'b00);
    repeat (4) step(1'b0, 2'b00, 2'b00);
    step(1'b0, 2'b00, 2'b10);
    repeat (2) step(1'b0, 2'b00, 2'b00);

    // randomized: mostly-held levels with occasional flips, clears and resets
    rd = 2'b00;
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic [1:0] c;
      for (int k = 0; k < 2; k++)
        if ($urandom_range(99) < 25) rd[k] = ~rd[k];
      r = ($urandom_range(99) < 2);
      c = 2'($urandom_range(3)) & {2{$urandom_range(99) < 20}};
      step(r, rd, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
